bin2gray: RTL and testbench
===========================

BIN2GRAY -- requirements
Module: bin2gray

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the sole clock and rst is synchronous to clk and active-high.
REQ-002 Parameter: WIDTH, default 4, code width in bits (legal range 2..32).
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: b  input  WIDTH  source code word (binary when mode=0, Gray when mode=1).
REQ-006 Port: in_valid  input  1  b/mode qualify on this cycle.
REQ-007 Port: mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary.
REQ-008 Port: g  output  WIDTH  registered converted word.
REQ-009 Port: out_valid  output  1  g updated on the previous accepted input.
REQ-010 Port order SHALL be clk, rst, b, g, in_valid, mode, out_valid, then the optional parity port.

Function
REQ-011 mode=0: result[WIDTH-1] = b[WIDTH-1]; result[i] = b[i+1] XOR b[i] for i < WIDTH-1; equivalently b XOR (b >> 1), logical shift.
REQ-012 mode=1: result[WIDTH-1] = b[WIDTH-1]; result[i] = result[i+1] XOR b[i], i.e. prefix XOR from the MSB downward.
REQ-013 Latency SHALL be exactly one clk cycle: on a rising edge with in_valid=1 and rst=0, g <= result and out_valid <= 1.
REQ-014 On a rising edge with in_valid=0 and rst=0, g SHALL hold its previous value and out_valid SHALL go to 0.
REQ-015 Back-to-back accepted inputs SHALL be supported every cycle with no stall and no back-pressure.
REQ-016 Conversion SHALL be purely combinational on b and mode feeding a single register stage, with no internal state beyond g, out_valid and the optional parity register.
REQ-017 The all-ones, all-zeros and MSB-only inputs SHALL follow REQ-011/REQ-012 with no special casing.
REQ-018 mode=1 applied to the mode=0 output of any value SHALL return the original value (round trip).

Reset
REQ-019 While rst=1 at a rising edge: g <= 0, out_valid <= 0, and parity <= 0 when present.
REQ-020 rst SHALL take priority over in_valid on the same edge, and the input presented on that edge SHALL be discarded.
REQ-021 The first edge with rst=0 and in_valid=1 SHALL produce a normal result one cycle later.

Configuration
REQ-022 With macro BIN2GRAY_PARITY_EN defined, the block SHALL add output parity (1 bit), registered alongside g, equal to the XOR-reduction of the result written to g.
REQ-023 Without BIN2GRAY_PARITY_EN, the parity port and its register SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-024 Reset: rst=1 for 2 cycles -> g=0000, out_valid=0.
REQ-025 WIDTH=4, mode=0, b=0110, in_valid=1 -> next cycle g=0101, out_valid=1 (parity=0 when enabled).
REQ-026 mode=0 sequence b=0000, 1000, 1111, 0111 on consecutive cycles -> g=0000, 1100, 1000, 0100 on consecutive cycles, with out_valid held at 1.
REQ-027 mode=1, b=0101 -> g=0110; mode=1, b=1000 -> g=1111.
REQ-028 Hold: after g=0101, drop in_valid with b=1111 -> g remains 0101 and out_valid=0.
REQ-029 Reset mid-stream: assert rst together with in_valid=1 and b=1010 -> next cycle g=0000 and out_valid=0; exhaustive round trip over all 16 values passes.

Source files
------------

// File: rtl/bin2gray.sv
// bin2gray: registered binary <-> Gray code converter.
//   mode = 0 : binary-to-Gray  (g = b ^ (b >> 1))
//   mode = 1 : Gray-to-binary  (prefix XOR from the MSB downward)
// One register stage, one cycle latency, accepts a new word every cycle.
// Optional feature: define BIN2GRAY_PARITY_EN to add a registered parity
// output equal to the XOR-reduction of the word written to g.
module bin2gray #(
  parameter int WIDTH = 4  // code width, legal range 2..32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g,
  input  logic             in_valid,
  input  logic             mode,
  output logic             out_valid
`ifdef BIN2GRAY_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] b2g;        // binary-to-Gray result
  logic [WIDTH-1:0] g2b;        // Gray-to-binary result
  logic [WIDTH-1:0] result;     // selected conversion result

  logic [WIDTH-1:0] g_q,         g_d;
  logic             out_valid_q, out_valid_d;

  // Binary-to-Gray: each bit is the XOR of itself and its upper neighbour.
  assign b2g = b ^ (b >> 1);

  // Gray-to-binary: running XOR walking from the MSB down to bit 0.
  always_comb begin
    logic acc;
    // NOTE: combinational blocks use blocking '=' so the running XOR is
    // read back in the same evaluation, and every output gets a default
    // first so no latch can be inferred.
    acc = 1'b0;
    g2b = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ b[i];
      g2b[i] = acc;
    end
  end

  assign result = mode ? g2b : b2g;

  // Next-state: load on an accepted input, otherwise hold g and drop valid.
  always_comb begin
    g_d         = g_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      g_d         = result;
      out_valid_d = 1'b1;
    end
  end

  // Output register stage with synchronous reset taking priority over input.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // together on the edge; reset is sampled synchronously here, not in the
    // sensitivity list.
    if (rst) begin
      g_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      g_q         <= g_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign g         = g_q;
  assign out_valid = out_valid_q;

`ifdef BIN2GRAY_PARITY_EN
  logic parity_q, parity_d;

  // Parity tracks g: recomputed only when g is loaded, held otherwise.
  always_comb begin
    parity_d = parity_q;
    if (in_valid) begin
      parity_d = ^result;
    end
  end

  // Parity register, reset and loaded alongside g.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_bin2gray.sv
// tb_bin2gray: scoreboard bench for bin2gray (WIDTH = 4).
// Stimulus pushes hand-computed expected words into a queue; a monitor on
// the falling edge pops and compares whenever out_valid is high.
module tb_bin2gray;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] b;
  logic [W-1:0] g;
  logic         in_valid;
  logic         mode;
  logic         out_valid;
`ifdef BIN2GRAY_PARITY_EN
  logic         parity;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] sb_q[$];

  // Hand-computed 4-bit Gray codes for binary 0..15.
  logic [W-1:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  bin2gray #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .b         (b),
    .g         (g),
    .in_valid  (in_valid),
    .mode      (mode),
    .out_valid (out_valid)
`ifdef BIN2GRAY_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic drive(input logic r, input logic v, input logic m, input logic [W-1:0] bb);
    rst      = r;
    in_valid = v;
    mode     = m;
    b        = bb;
    @(posedge clk);
    #1;
  endtask

  // Accepted input with its expected result queued for the monitor.
  task automatic issue(input logic m, input logic [W-1:0] bb, input logic [W-1:0] exp);
    sb_q.push_back(exp);
    drive(1'b0, 1'b1, m, bb);
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        logic [W-1:0] exp;
        exp = sb_q.pop_front();
        check("g", {28'd0, g}, {28'd0, exp});
`ifdef BIN2GRAY_PARITY_EN
        check("parity", {31'd0, parity}, {31'd0, ^exp});
`endif
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; b = '0;

    // Reset held for two cycles.
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    check("reset_g", {28'd0, g}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef BIN2GRAY_PARITY_EN
    check("reset_parity", {31'd0, parity}, 32'd0);
`endif

    // Single conversion.
    issue(1'b0, 4'b0110, 4'b0101);
    check("first_out_valid", {31'd0, out_valid}, 32'd1);

    // Hold: in_valid low, g keeps 0101, out_valid drops.
    drive(1'b0, 1'b0, 1'b0, 4'b1111);
    check("hold_g", {28'd0, g}, 32'h5);
    check("hold_out_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back binary-to-Gray including all-zeros, MSB-only, all-ones.
    issue(1'b0, 4'b0000, 4'b0000);
    check("b2b_valid0", {31'd0, out_valid}, 32'd1);
    issue(1'b0, 4'b1000, 4'b1100);
    check("b2b_valid1", {31'd0, out_valid}, 32'd1);
    issue(1'b0, 4'b1111, 4'b1000);
    check("b2b_valid2", {31'd0, out_valid}, 32'd1);
    issue(1'b0, 4'b0111, 4'b0100);
    check("b2b_valid3", {31'd0, out_valid}, 32'd1);

    // Gray-to-binary.
    issue(1'b1, 4'b0101, 4'b0110);
    issue(1'b1, 4'b1000, 4'b1111);
    issue(1'b1, 4'b1111, 4'b1010);

    // Reset mid-stream wins over a valid input, which is discarded.
    issue(1'b0, 4'b0011, 4'b0010);
    drive(1'b1, 1'b1, 1'b0, 4'b1010);
    check("midrst_g", {28'd0, g}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);

    // First accepted input after reset gives a normal result.
    issue(1'b0, 4'b1010, 4'b1111);

    // Exhaustive round trip using the hand-computed Gray table.
    for (int v = 0; v < 16; v++) begin
      logic [W-1:0] bin;
      bin = v[W-1:0];
      issue(1'b0, bin, gray_tab[v]);
      issue(1'b1, gray_tab[v], bin);
    end

    // Drain and confirm every queued result was presented.
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
